// File: rtl/div_seq_unit.sv
// div_seq_unit: sequential restoring divider for the EX stage; remainder goes to HI and quotient to LO.
// Optional build macro DIV_EARLY_ZERO_EN: a zero divisor retires one cycle after it is accepted.
module div_seq_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic             flush,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
    logic [WIDTH-1:0] r;
    if (en) begin
      r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  assign a_neg   = signed_op & dividend[WIDTH-1];
  assign b_neg   = signed_op & divisor[WIDTH-1];
  // Trial subtraction is one bit wider so its MSB is the borrow.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  // Next-state, datapath step and result update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    zero_d  = zero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            dvd_d   = dividend;
            rem_d   = ZERO_W;
            quo_d   = neg_if(dividend, a_neg);
            dvs_d   = neg_if(divisor, b_neg);
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
            zero_d  = (divisor == ZERO_W);
            cnt_d   = CNT_ZERO;
`ifdef DIV_EARLY_ZERO_EN
            if (divisor == ZERO_W) begin
              state_d = S_DONE;
              hi_d    = dividend;
              lo_d    = ONES_W;
              dbz_d   = 1'b1;
            end else begin
              state_d = S_CALC;
            end
`else
            state_d = S_CALC;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CALC: begin
          if (trial[WIDTH] == 1'b0) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = S_SIGN;
          end else begin
            state_d = S_CALC;
          end
        end
        S_SIGN: begin
          // Sign fix-up is folded into the HI/LO write so results are valid while done is high.
          if (zero_q) begin
            hi_d  = dvd_q;
            lo_d  = ONES_W;
            dbz_d = 1'b1;
          end else begin
            hi_d  = neg_if(rem_q, r_neg_q);
            lo_d  = neg_if(quo_q, q_neg_q);
            dbz_d = 1'b0;
          end
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      rem_q   <= ZERO_W;
      quo_q   <= ZERO_W;
      dvs_q   <= ZERO_W;
      dvd_q   <= ZERO_W;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      zero_q  <= 1'b0;
      hi_q    <= ZERO_W;
      lo_q    <= ZERO_W;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      zero_q  <= zero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign stall       = busy_q | (start & (state_q == S_IDLE));

endmodule

// File: tb/tb_div_seq_unit.sv
// tb_div_seq_unit: scoreboard bench for div_seq_unit; expected results come from plain integer division.
// Honours DIV_EARLY_ZERO_EN for the zero-divisor latency.
module tb_div_seq_unit;

  localparam int  W        = 32;
  localparam time PER      = 10;
  localparam int  LAT_NORM = 34;
`ifdef DIV_EARLY_ZERO_EN
  localparam int  LAT_ZERO = 1;
`else
  localparam int  LAT_ZERO = 34;
`endif

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
    time          t_acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, stall, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t last_exp;

  div_seq_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op), .flush(flush),
    .dividend(dividend), .divisor(divisor), .busy(busy), .stall(stall), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #(PER/2) clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int   sa, sbv;
    sa = a;
    sbv = b;
    e.t_acc = 0;
    if (b == 32'd0) begin
      e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1; e.lat = LAT_ZERO;
    end else begin
      e.dbz = 1'b0; e.lat = LAT_NORM;
      if (!s) begin
        e.lo = a / b; e.hi = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.lo = 32'h8000_0000; e.hi = 32'd0;
      end else begin
        e.lo = sa / sbv; e.hi = sa % sbv;
      end
    end
    return e;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy === 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", n);
    end
  endtask

  // Issue one op when idle; the edge following start is the accepting edge.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit push);
    exp_t e;
    wait_idle();
    dividend = a; divisor = b; signed_op = s; start = 1'b1;
    @(posedge clk);
    if (push) begin
      e = model(a, b, s);
      e.t_acc = $time;
      sb.push_back(e);
      last_exp = e;
    end
    #1 start = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    int   cyc;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: done=1 with no op outstanding at %0t", $time);
        end else begin
          e = sb.pop_front();
          cyc = int'(($time - e.t_acc - PER/2) / PER) + 1;
          chk("hi", hi, e.hi);
          chk("lo", lo, e.lo);
          chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
          chk("done_latency", cyc, e.lat);
        end
      end
    end
  end

  initial begin
    int           bad;
    logic [W-1:0] ra, rb;
    last_exp = model(32'd0, 32'd1, 1'b0);
    last_exp.hi = '0; last_exp.lo = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_stall", {31'd0, stall}, 32'd0);

    // divu 100/7 with stall watched for the whole op and an ignored start mid-op.
    dividend = 32'd100; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
    #1 chk("stall_on_start", {31'd0, stall}, 32'd1);
    @(posedge clk);
    begin
      exp_t e;
      e = model(32'd100, 32'd7, 1'b0);
      e.t_acc = $time;
      sb.push_back(e);
      last_exp = e;
    end
    #1 start = 1'b0;
    bad = 0;
    for (int i = 0; i < LAT_NORM; i++) begin
      @(negedge clk);
      if (stall !== 1'b1) bad++;
      if (i == 5) begin dividend = 32'd1; divisor = 32'd1; start = 1'b1; end
      if (i == 6) start = 1'b0;
    end
    chk("stall_held_cycles_low", bad, 32'd0);

    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    do_op(32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1);
    do_op(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    wait_idle();

    // Flush mid-op: no done, previous results kept.
    do_op(32'd9, 32'd3, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_hi", hi, last_exp.hi);
    chk("flush_lo", lo, last_exp.lo);
    chk("flush_dbz", {31'd0, div_by_zero}, {31'd0, last_exp.dbz});
    repeat (40) @(posedge clk);
    #1;

    // flush beats start in the same cycle.
    dividend = 32'd50; divisor = 32'd5; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    chk("flush_over_start", {31'd0, busy}, 32'd0);

    // Back-to-back: start held through DONE is accepted on the DONE-exit edge.
    dividend = 32'd9; divisor = 32'd3; signed_op = 1'b0; start = 1'b1;
    @(posedge clk);
    begin
      exp_t e;
      e = model(32'd9, 32'd3, 1'b0);
      e.t_acc = $time;
      sb.push_back(e);
      repeat (LAT_NORM) @(posedge clk);
      e.t_acc = $time;
      sb.push_back(e);
      last_exp = e;
    end
    #1 start = 1'b0;
    wait_idle();

    // Randomized ops against the reference model.
    for (int n = 0; n < 60; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'd1;
        3:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      do_op(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle();

    // Reset mid-op clears everything asynchronously.
    do_op(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
